// File: rtl/prio_irq_pkg.sv
// Shared types and helpers for the clocked priority interrupt encoder.
//   irq_state_e : handshake FSM states (IDLE, REQ, SERV)
//   vec_width() : encoded vector width for a given number of request lines
package prio_irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } irq_state_e;

  // A 2-line encoder still needs one vector bit, hence the floor of 1.
  function automatic int unsigned vec_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find.sv
// Highest-index-wins priority finder (purely combinational).
//   eligible_i : candidate lines, bit N-1 has the highest priority
//   idx_o      : index of the highest set bit (0 when none set)
//   any_o      : at least one bit of eligible_i is set
module prio_find
  import prio_irq_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = vec_width(N)
) (
  input  logic [N-1:0] eligible_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Ascending scan: later (higher) set bits overwrite earlier ones.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      idx_o = eligible_i[i] ? W'(i) : idx_o;
    end
    any_o = |eligible_i;
  end

endmodule

// File: rtl/prio_irq_encoder.sv
// Clocked, cascadable priority interrupt encoder with IRQ/ACK/EOI handshake.
//   clk, nRST : rising-edge clock, asynchronous active-low reset
//   nS        : active-low enable (cascade input)
//   nREQ      : active-low request lines, bit N-1 highest priority
//   mask_we   : load mask register from mask_d (1 = line masked)
//   ack, eoi  : vector accepted / end of service pulses
//   nIRQ      : active-low interrupt request
//   nY        : active-low encoded vector, held from capture to next capture
//   nGS, nEO  : group-select / enable-out, registered from eligibility and nS
//   busy      : handshake in progress (REQ or SERV)
module prio_irq_encoder
  import prio_irq_pkg::*;
#(
  parameter  int N    = 8,
  parameter  bit EDGE = 1'b1,
  localparam int W    = vec_width(N)
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         nS,
  input  logic [N-1:0] nREQ,
  input  logic         mask_we,
  input  logic [N-1:0] mask_d,
  input  logic         ack,
  input  logic         eoi,
  output logic         nIRQ,
  output logic [W-1:0] nY,
  output logic         nGS,
  output logic         nEO,
  output logic         busy
);

  logic [N-1:0] samp_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] mask_q;
  irq_state_e   state_q, state_d;
  logic [W-1:0] vec_q, vec_d;
  logic         nirq_q, ngs_q, neo_q, busy_q;
  logic [W-1:0] ny_q;

  logic [N-1:0] set_s, clr_s, elig_s;
  logic [W-1:0] win_s;
  logic         any_s;
  logic         take_s;
  logic         cap_s;

  // Masking only gates selection; pending keeps accumulating underneath.
  assign elig_s = pend_q & ~mask_q;

  // Edge mode compares against last sample (reset to ones, so a line held
  // low through reset release counts as a fresh falling edge).
  assign set_s = EDGE ? (samp_q & ~nREQ) : ~nREQ;

  prio_find #(.N(N)) u_find (
    .eligible_i (elig_s),
    .idx_o      (win_s),
    .any_o      (any_s)
  );

  // Handshake FSM next-state logic; ack takes precedence over withdrawal.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    take_s  = 1'b0;
    cap_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!nS && any_s) begin
          state_d = REQ;
          vec_d   = win_s;
          cap_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (ack) begin
          state_d = SERV;
          take_s  = 1'b1;
        end else if (nS) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      SERV: begin
        if (eoi) begin
          state_d = IDLE;
        end else begin
          state_d = SERV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pending update: a same-cycle set on the acked line overrides the clear.
  always_comb begin
    clr_s  = take_s ? (N'(1) << vec_q) : '0;
    pend_d = (pend_q & ~clr_s) | set_s;
  end

  // Sampling, pending, mask and FSM state registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      samp_q  <= '1;
      pend_q  <= '0;
      mask_q  <= '0;
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      samp_q  <= nREQ;
      pend_q  <= pend_d;
      mask_q  <= mask_we ? mask_d : mask_q;
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // Output registers, derived from next state so they align with the FSM.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      nirq_q <= 1'b1;
      ny_q   <= '1;
      ngs_q  <= 1'b1;
      neo_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      nirq_q <= (state_d != REQ);
      ny_q   <= cap_s ? ~vec_d : ny_q;
      ngs_q  <= ~(~nS & any_s);
      neo_q  <= ~(~nS & ~any_s);
      busy_q <= (state_d != IDLE);
    end
  end

  assign nIRQ = nirq_q;
  assign nY   = ny_q;
  assign nGS  = ngs_q;
  assign nEO  = neo_q;
  assign busy = busy_q;

endmodule
